// File: rtl/phase_steer_filter_pkg.sv
// ---------------------------------------------------------------------------
// phase_steer_pkg
// Shared types and constants for the beacon phase steering filter.
//   steer_state_e : steering FSM encoding (IDLE=0, ACQ=1, TRACK=2, HOLD=3)
//   PHASE_W       : width of the detector's unsigned phase magnitude
//   SPHASE_W      : width of a signed phase sample (magnitude + sign)
//   signed_phase(): converts magnitude + lead direction into a signed sample
// ---------------------------------------------------------------------------
package phase_steer_pkg;

  localparam int PHASE_W  = 16;
  localparam int SPHASE_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_HOLD  = 2'd3
  } steer_state_e;

  // Left channel leading is the positive direction; the extra bit keeps
  // -65535 representable without wrap.
  function automatic logic signed [SPHASE_W-1:0] signed_phase(
    input logic [PHASE_W-1:0] mag,
    input logic               left_first
  );
    logic signed [SPHASE_W-1:0] ext;
    ext = $signed({1'b0, mag});
    return left_first ? ext : -ext;
  endfunction

endpackage

// File: rtl/phase_steer_filter_sample_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
// Free-running divider producing a one-cycle sample tick every SAMPLE_DIV
// clocks. The tick is high while the counter sits at SAMPLE_DIV-1.
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset (counter returns to 0)
//   tick : one-cycle sample strobe
// ---------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 10000
) (
  input  logic CLK,
  input  logic nRST,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/phase_steer_filter.sv
// ---------------------------------------------------------------------------
// phase_steer_filter
// Turns the 19 kHz beacon phase detector output into a steering decision.
// Samples the detector on a divided tick, averages 2^AVG_LOG2 signed samples,
// and classifies the average against a symmetric deadband. Short signal
// dropouts hold the last decision; LOSS_HOLD consecutive misses drop it.
//   CLK          : system clock, rising edge
//   nRST         : asynchronous active-low reset
//   PhaseOUT     : unsigned phase magnitude from the detector
//   LeftFirst    : 1 = left channel leads (positive phase)
//   SignalDetect : 1 = detector sees a valid beacon
//   SteerAvg     : signed windowed average phase
//   TurnLeft     : SteerAvg > +DEADBAND
//   TurnRight    : SteerAvg < -DEADBAND
//   OnTarget     : |SteerAvg| <= DEADBAND while SteerValid
//   SteerValid   : high in TRACK and HOLD
//   SteerStrobe  : one-cycle pulse on each new SteerAvg
// ---------------------------------------------------------------------------
module phase_steer_filter
  import phase_steer_pkg::*;
#(
  parameter int SAMPLE_DIV = 10000,
  parameter int AVG_LOG2   = 3,
  parameter int DEADBAND   = 16,
  parameter int LOSS_HOLD  = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [PHASE_W-1:0]         PhaseOUT,
  input  logic                       LeftFirst,
  input  logic                       SignalDetect,
  output logic signed [SPHASE_W-1:0] SteerAvg,
  output logic                       TurnLeft,
  output logic                       TurnRight,
  output logic                       OnTarget,
  output logic                       SteerValid,
  output logic                       SteerStrobe
);

  // Accumulator carries AVG_LOG2 guard bits so a full window never overflows.
  localparam int ACC_W  = SPHASE_W + AVG_LOG2;
  localparam int MISS_W = $clog2(LOSS_HOLD + 1);

  localparam logic [AVG_LOG2-1:0]        CNT_LAST  = '1;
  localparam logic [MISS_W-1:0]          MISS_LAST = MISS_W'(LOSS_HOLD - 1);
  localparam logic signed [SPHASE_W-1:0] DB_POS    = SPHASE_W'(DEADBAND);
  localparam logic signed [SPHASE_W-1:0] DB_NEG    = -DB_POS;

  // Window mean with floor rounding: arithmetic shift rounds toward -inf.
  // The mean of SPHASE_W-bit samples always fits back into SPHASE_W bits.
  function automatic logic signed [SPHASE_W-1:0] window_avg(
    input logic signed [ACC_W-1:0] sum
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> AVG_LOG2;
    return shifted[SPHASE_W-1:0];
  endfunction

  logic tick;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .CLK (CLK),
    .nRST(nRST),
    .tick(tick)
  );

  steer_state_e               state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0]        cnt_q, cnt_d;
  logic [MISS_W-1:0]          miss_q, miss_d;
  logic signed [SPHASE_W-1:0] avg_q, avg_d;
  logic                       left_q, left_d;
  logic                       right_q, right_d;
  logic                       on_q, on_d;
  logic                       valid_q, valid_d;
  logic                       strobe_q, strobe_d;

  logic signed [SPHASE_W-1:0] sample;
  logic signed [ACC_W-1:0]    sample_ext;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [SPHASE_W-1:0] avg_new;

  assign sample     = signed_phase(PhaseOUT, LeftFirst);
  assign sample_ext = {{AVG_LOG2{sample[SPHASE_W-1]}}, sample};
  assign acc_sum    = acc_q + sample_ext;
  assign avg_new    = window_avg(acc_sum);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    avg_d    = avg_q;
    left_d   = left_q;
    right_d  = right_q;
    on_d     = on_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (SignalDetect) begin
            state_d = ST_ACQ;
            acc_d   = sample_ext;
            cnt_d   = AVG_LOG2'(1);
          end
        end

        ST_ACQ, ST_TRACK: begin
          if (SignalDetect) begin
            if (cnt_q == CNT_LAST) begin
              // Last sample of the window: publish and restart the window.
              state_d  = ST_TRACK;
              valid_d  = 1'b1;
              avg_d    = avg_new;
              left_d   = (avg_new > DB_POS);
              right_d  = (avg_new < DB_NEG);
              on_d     = !(avg_new > DB_POS) && !(avg_new < DB_NEG);
              strobe_d = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + AVG_LOG2'(1);
            end
          end else begin
            // A dropout discards any partial window.
            acc_d = '0;
            cnt_d = '0;
            if (state_q == ST_TRACK) begin
              state_d = ST_HOLD;
              miss_d  = MISS_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_HOLD: begin
          if (SignalDetect) begin
            state_d = ST_TRACK;
            miss_d  = '0;
            acc_d   = sample_ext;
            cnt_d   = AVG_LOG2'(1);
          end else if (miss_q == MISS_LAST) begin
            state_d = ST_IDLE;
            miss_d  = '0;
            avg_d   = '0;
            left_d  = 1'b0;
            right_d = 1'b0;
            on_d    = 1'b0;
            valid_d = 1'b0;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      miss_q   <= '0;
      avg_q    <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      on_q     <= 1'b0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      avg_q    <= avg_d;
      left_q   <= left_d;
      right_q  <= right_d;
      on_q     <= on_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign SteerAvg    = avg_q;
  assign TurnLeft    = left_q;
  assign TurnRight   = right_q;
  assign OnTarget    = on_q;
  assign SteerValid  = valid_q;
  assign SteerStrobe = strobe_q;

endmodule

// File: tb/tb_phase_steer_filter.sv
// ---------------------------------------------------------------------------
// tb_phase_steer_filter
// Self-checking bench for phase_steer_filter with a small configuration
// (SAMPLE_DIV=4, AVG_LOG2=2, DEADBAND=16, LOSS_HOLD=3). A window-of-samples
// model predicts every output on every cycle; literal checks pin key values.
// ---------------------------------------------------------------------------
module tb_phase_steer_filter;

  localparam int SAMPLE_DIV = 4;
  localparam int AVG_LOG2   = 2;
  localparam int DEADBAND   = 16;
  localparam int LOSS_HOLD  = 3;
  localparam int WIN        = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] phase_in = '0;
  logic        left_first = 1'b0;
  logic        sig_det = 1'b0;

  logic [16:0] steer_avg;
  logic        turn_left, turn_right, on_target, steer_valid, steer_strobe;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  phase_steer_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .AVG_LOG2  (AVG_LOG2),
    .DEADBAND  (DEADBAND),
    .LOSS_HOLD (LOSS_HOLD)
  ) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .PhaseOUT    (phase_in),
    .LeftFirst   (left_first),
    .SignalDetect(sig_det),
    .SteerAvg    (steer_avg),
    .TurnLeft    (turn_left),
    .TurnRight   (turn_right),
    .OnTarget    (on_target),
    .SteerValid  (steer_valid),
    .SteerStrobe (steer_strobe)
  );

  // Behavioural model state
  int m_phase  = 0;
  int m_avg    = 0;
  bit m_left   = 1'b0;
  bit m_right  = 1'b0;
  bit m_on     = 1'b0;
  bit m_valid  = 1'b0;
  bit m_strobe = 1'b0;
  int m_misses = 0;
  int win[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_avg    = 0;
    m_left   = 1'b0;
    m_right  = 1'b0;
    m_on     = 1'b0;
    m_valid  = 1'b0;
    m_strobe = 1'b0;
    m_misses = 0;
    win.delete();
  endtask

  task automatic model_step();
    bit tick;
    int s, sum, q;
    m_strobe = 1'b0;
    tick     = (m_phase == SAMPLE_DIV - 1);
    m_phase  = (m_phase + 1) % SAMPLE_DIV;
    if (!tick) return;
    if (sig_det) begin
      m_misses = 0;
      s = left_first ? int'(phase_in) : -int'(phase_in);
      win.push_back(s);
      if (win.size() == WIN) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        q = sum / WIN;
        if ((sum % WIN) != 0 && sum < 0) q = q - 1;
        m_avg    = q;
        m_left   = (q > DEADBAND);
        m_right  = (q < -DEADBAND);
        m_on     = (q >= -DEADBAND) && (q <= DEADBAND);
        m_valid  = 1'b1;
        m_strobe = 1'b1;
        win.delete();
      end
    end else begin
      win.delete();
      if (m_valid) begin
        m_misses++;
        if (m_misses == LOSS_HOLD) begin
          m_valid  = 1'b0;
          m_avg    = 0;
          m_left   = 1'b0;
          m_right  = 1'b0;
          m_on     = 1'b0;
          m_misses = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_avg",    $signed(steer_avg), m_avg);
      check("cyc_left",   int'(turn_left),    int'(m_left));
      check("cyc_right",  int'(turn_right),   int'(m_right));
      check("cyc_on",     int'(on_target),    int'(m_on));
      check("cyc_valid",  int'(steer_valid),  int'(m_valid));
      check("cyc_strobe", int'(steer_strobe), int'(m_strobe));
    end
  end

  task automatic tick_with(input int p, input bit lf, input bit sd);
    phase_in   = 16'(p);
    left_first = lf;
    sig_det    = sd;
    repeat (SAMPLE_DIV) @(negedge clk);
  endtask

  task automatic check_out(input string name, input int raw_avg, input bit l,
                           input bit r, input bit o, input bit v, input bit s);
    check({name, "_avg"},    int'(steer_avg),    raw_avg);
    check({name, "_left"},   int'(turn_left),    int'(l));
    check({name, "_right"},  int'(turn_right),   int'(r));
    check({name, "_on"},     int'(on_target),    int'(o));
    check({name, "_valid"},  int'(steer_valid),  int'(v));
    check({name, "_strobe"}, int'(steer_strobe), int'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: steady +100, strobe pulse and 16-clock period
    repeat (4) tick_with(100, 1, 1);
    check_out("s1_first", 100, 1, 0, 0, 1, 1);
    @(negedge clk);
    check("s1_pulse_end", int'(steer_strobe), 0);
    repeat (SAMPLE_DIV - 1) @(negedge clk);
    repeat (3) tick_with(100, 1, 1);
    check_out("s1_second", 100, 1, 0, 0, 1, 1);

    // 2: negative, deadband edge, floor rounding
    repeat (4) tick_with(40, 0, 1);
    check_out("s2_neg", 'h1FFD8, 0, 1, 0, 1, 1);
    repeat (4) tick_with(16, 1, 1);
    check_out("s2_edge", 16, 0, 0, 1, 1, 1);
    tick_with(1, 0, 1);
    repeat (3) tick_with(0, 1, 1);
    check_out("s2_floor", 'h1FFFF, 0, 0, 1, 1, 1);

    // 3: full-scale magnitudes
    repeat (4) tick_with(65535, 1, 1);
    check_out("s3_pos", 'h0FFFF, 1, 0, 0, 1, 1);
    repeat (4) tick_with(65535, 0, 1);
    check_out("s3_neg", 'h10001, 0, 1, 0, 1, 1);

    // 4: short dropout holds, reacquire, then loss
    repeat (2) tick_with(0, 1, 0);
    check_out("s4_hold", 'h10001, 0, 1, 0, 1, 0);
    repeat (3) tick_with(20, 1, 1);
    check_out("s4_reacq_pending", 'h10001, 0, 1, 0, 1, 0);
    tick_with(20, 1, 1);
    check_out("s4_reacq", 20, 1, 0, 0, 1, 1);
    repeat (2) tick_with(0, 1, 0);
    check_out("s4_miss2", 20, 1, 0, 0, 1, 0);
    tick_with(0, 1, 0);
    check_out("s4_lost", 0, 0, 0, 0, 0, 0);

    // 5: dropout during acquisition discards the partial sum
    repeat (2) tick_with(200, 1, 1);
    tick_with(0, 1, 0);
    repeat (3) tick_with(8, 1, 1);
    check_out("s5_pending", 0, 0, 0, 0, 0, 0);
    tick_with(8, 1, 1);
    check_out("s5_done", 8, 0, 0, 1, 1, 1);

    // 6: asynchronous reset mid-window
    repeat (2) tick_with(50, 1, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_out("s6_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick_with(30, 1, 1);
    check_out("s6_pending", 0, 0, 0, 0, 0, 0);
    tick_with(30, 1, 1);
    check_out("s6_first", 30, 1, 0, 0, 1, 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
